// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder with majority carry
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full-adder cell over WIDTH bits, LSB first
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sum bits enter the top of the A shifter as A's bits leave the bottom,
  // so the shifter holds the full sum after WIDTH steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= {bit_s, a_sh[WIDTH-1:1]};
          b_sh  <= b_sh >> 1;
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_q  <= {bit_s, a_sh[WIDTH-1:1]};
            cout_q <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int exp_accepts = 0;
  int accept_cyc[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      accepts++;
      accept_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int hold, input bit pulse);
    logic [W:0] ref_v;
    int n;
    int busy_n;
    ref_v = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_wait", {31'd0, n < 50}, 32'd1);
    step();
    exp_accepts++;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    n = 0;
    busy_n = 0;
    while (!out_valid && n < 50) begin
      busy_n += int'(busy);
      if (pulse && n == 3) begin
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else if (n == 4) begin
        in_valid = 1'b0;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, W);
    check("busy_cycles", busy_n, W);
    check("sum", {24'd0, sum}, {24'd0, ref_v[W-1:0]});
    check("cout", {31'd0, cout}, {31'd0, ref_v[W]});
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_sum", {24'd0, sum}, {24'd0, ref_v[W-1:0]});
      check("hold_cout", {31'd0, cout}, {31'd0, ref_v[W]});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_sum", {24'd0, sum}, {24'd0, ref_v[W-1:0]});
    check("release_cout", {31'd0, cout}, {31'd0, ref_v[W]});
  endtask

  initial begin
    int base;
    int n;

    repeat (2) step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b1, 5, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b1);

    // Back-to-back acceptances with the consumer always ready.
    out_ready = 1'b1;
    a = 8'h01;
    b = 8'h01;
    cin = 1'b0;
    base = accept_cyc.size();
    in_valid = 1'b1;
    n = 0;
    while (accept_cyc.size() < base + 3 && n < 200) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    exp_accepts += 3;
    check("b2b_count", {31'd0, accept_cyc.size() >= base + 3}, 32'd1);
    if (accept_cyc.size() >= base + 3) begin
      check("b2b_gap0", accept_cyc[base+1] - accept_cyc[base], W + 2);
      check("b2b_gap1", accept_cyc[base+2] - accept_cyc[base+1], W + 2);
    end
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("b2b_drain", {31'd0, in_ready}, 32'd1);
    check("b2b_sum", {24'd0, sum}, 32'h02);
    out_ready = 1'b0;

    // Abort mid-RUN: the edge that would process bit 4 sees reset instead.
    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    a = 8'hC3;
    b = 8'h7E;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    exp_accepts++;
    in_valid = 1'b0;
    repeat (4) step();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) step();
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    check("accept_total", accepts, exp_accepts);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
